// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus arbiter and its producer FIFOs.
package cdb_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int SRC_W  = 2;

  localparam logic [SRC_W-1:0] REQ_ALU0 = 2'd0;
  localparam logic [SRC_W-1:0] REQ_ALU1 = 2'd1;
  localparam logic [SRC_W-1:0] REQ_ALU2 = 2'd2;
  localparam logic [SRC_W-1:0] REQ_LSQ  = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-producer skid FIFO; full is derived from registered count only.
module cdb_req_fifo
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  cdb_entry_t       wr_entry,
  output cdb_entry_t       rd_entry,
  output logic [PTR_W:0]   count,
  output logic             full
);

  cdb_entry_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses the push even when it is popped in the same cycle.
  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign do_push  = push & ~full & ~flush;
  assign do_pop   = pop & (count != '0) & ~flush;
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to NUM_GRANT producer FIFO heads onto registered CDB ports.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_GRANT  = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        cdb_stall,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_pc,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_GRANT-1:0]        cdb_valid,
  output logic [NUM_GRANT*DATA_W-1:0] cdb_pc,
  output logic [NUM_GRANT*TAG_W-1:0]  cdb_tag,
  output logic [NUM_GRANT*DATA_W-1:0] cdb_data,
  output logic [NUM_GRANT*SRC_W-1:0]  cdb_src,
  output logic                        overflow_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  cdb_entry_t                       head  [NUM_REQ];
  logic [PTR_W:0]                   count [NUM_REQ];
  logic [NUM_REQ-1:0]               full;
  logic [NUM_REQ-1:0]               grant;
  logic [NUM_REQ-1:0]               pop;
  logic [NUM_GRANT-1:0]             port_vld;
  logic [NUM_GRANT-1:0][SRC_W-1:0]  port_sel;
  logic [SRC_W-1:0]                 last_idx;
  logic [SRC_W-1:0]                 rr_ptr;
  logic [SRC_W-1:0]                 rr_next;

  logic [NUM_GRANT-1:0]             vld_p1;
  logic [NUM_GRANT-1:0][DATA_W-1:0] pc_p1;
  logic [NUM_GRANT-1:0][TAG_W-1:0]  tag_p1;
  logic [NUM_GRANT-1:0][DATA_W-1:0] data_p1;
  logic [NUM_GRANT-1:0][SRC_W-1:0]  src_p1;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    cdb_entry_t wr_entry;
    assign wr_entry = '{pc:   req_pc[i*DATA_W +: DATA_W],
                        tag:  req_tag[i*TAG_W +: TAG_W],
                        data: req_data[i*DATA_W +: DATA_W]};
    cdb_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (req_valid[i]),
      .pop      (pop[i]),
      .flush    (flush),
      .wr_entry (wr_entry),
      .rd_entry (head[i]),
      .count    (count[i]),
      .full     (full[i])
    );
  end

  assign req_ready = ~full;
  assign pop       = grant & {NUM_REQ{~cdb_stall & ~flush}};

  // Stage p0: scan from rr_ptr, filling ports in order with eligible heads.
  always_comb begin
    logic [SRC_W-1:0] idx;
    logic             placed;
    idx      = '0;
    placed   = 1'b0;
    grant    = '0;
    port_vld = '0;
    port_sel = '0;
    last_idx = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx    = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
      placed = 1'b0;
      if (count[idx] != '0) begin
        for (int g = 0; g < NUM_GRANT; g++) begin
          if (!placed && !port_vld[g]) begin
            port_vld[g] = 1'b1;
            port_sel[g] = idx;
            grant[idx]  = 1'b1;
            last_idx    = idx;
            placed      = 1'b1;
          end
        end
      end
    end
    rr_next = SRC_W'((int'(last_idx) + 1) % NUM_REQ);
  end

  // Stage p1: registered broadcast ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      vld_p1       <= '0;
      pc_p1        <= '0;
      tag_p1       <= '0;
      data_p1      <= '0;
      src_p1       <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (|(req_valid & full)) overflow_err <= 1'b1;
      if (flush || cdb_stall) begin
        vld_p1 <= '0;
      end else begin
        vld_p1 <= port_vld;
        if (|port_vld) rr_ptr <= rr_next;
        for (int g = 0; g < NUM_GRANT; g++) begin
          if (port_vld[g]) begin
            pc_p1[g]   <= head[port_sel[g]].pc;
            tag_p1[g]  <= head[port_sel[g]].tag;
            data_p1[g] <= head[port_sel[g]].data;
            src_p1[g]  <= port_sel[g];
          end
        end
      end
    end
  end

  assign cdb_valid = vld_p1;
  assign cdb_pc    = pc_p1;
  assign cdb_tag   = tag_p1;
  assign cdb_data  = data_p1;
  assign cdb_src   = src_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin order, backpressure, flush and reset.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NR = 4;
  localparam int NG = 2;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 cdb_stall;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR*DATA_W-1:0] req_pc;
  logic [NR*TAG_W-1:0]  req_tag;
  logic [NR*DATA_W-1:0] req_data;
  logic [NG-1:0]        cdb_valid;
  logic [NG*DATA_W-1:0] cdb_pc;
  logic [NG*TAG_W-1:0]  cdb_tag;
  logic [NG*DATA_W-1:0] cdb_data;
  logic [NG*SRC_W-1:0]  cdb_src;
  logic                 overflow_err;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_GRANT(NG), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .cdb_stall    (cdb_stall),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pc       (req_pc),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .cdb_valid    (cdb_valid),
    .cdb_pc       (cdb_pc),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_src      (cdb_src),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DATA_W-1:0] pc,
                         input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    req_valid[i]             = 1'b1;
    req_pc[i*DATA_W +: DATA_W] = pc;
    req_tag[i*TAG_W +: TAG_W]  = tag;
    req_data[i*DATA_W +: DATA_W] = data;
  endtask

  task automatic apply_reset;
    rst       = 1'b1;
    flush     = 1'b0;
    cdb_stall = 1'b0;
    req_valid = '0;
    req_pc    = '0;
    req_tag   = '0;
    req_data  = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if (cdb_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", cdb_valid); end
    checks++;
    if (req_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready got %b want 1111", req_ready); end
    checks++;
    if ({cdb_pc, cdb_tag, cdb_data, cdb_src, overflow_err} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero pc=%h tag=%h data=%h src=%h ovf=%b", cdb_pc, cdb_tag, cdb_data, cdb_src, overflow_err);
    end
  endtask

  task automatic test_single_push;
    apply_reset();
    set_req(2, 32'h40, 6'd5, 32'hDEAD);
    tick();
    req_valid = '0;
    checks++;
    if (cdb_valid !== 2'b00) begin errors++; $display("FAIL single_early got %b want 00", cdb_valid); end
    tick();
    checks++;
    if (cdb_valid !== 2'b01) begin errors++; $display("FAIL single_valid got %b want 01", cdb_valid); end
    checks++;
    if ({cdb_pc[31:0], cdb_tag[5:0], cdb_data[31:0], cdb_src[1:0]} !== {32'h40, 6'd5, 32'hDEAD, 2'd2}) begin
      errors++; $display("FAIL single_port0 got pc=%h tag=%0d data=%h src=%0d want 40 5 dead 2", cdb_pc[31:0], cdb_tag[5:0], cdb_data[31:0], cdb_src[1:0]);
    end
    checks++;
    if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL single_rr got %0d want 3", dut.rr_ptr); end
    tick();
    checks++;
    if (cdb_valid !== 2'b00) begin errors++; $display("FAIL single_idle got %b want 00", cdb_valid); end
  endtask

  task automatic test_all_four;
    apply_reset();
    for (int i = 0; i < NR; i++) set_req(i, 32'h100 + 32'(i), 6'(10 + i), 32'hA0 + 32'(i));
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_src !== {2'd1, 2'd0}) begin
      errors++; $display("FAIL all4_first got valid=%b src=%h want 11 src=4", cdb_valid, cdb_src);
    end
    checks++;
    if (cdb_data !== {32'hA1, 32'hA0} || cdb_tag !== {6'd11, 6'd10}) begin
      errors++; $display("FAIL all4_first_data got data=%h tag=%h", cdb_data, cdb_tag);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_src !== {2'd3, 2'd2}) begin
      errors++; $display("FAIL all4_second got valid=%b src=%h want 11 src=e", cdb_valid, cdb_src);
    end
    checks++;
    if (cdb_pc !== {32'h103, 32'h102}) begin errors++; $display("FAIL all4_second_pc got %h", cdb_pc); end
    checks++;
    if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL all4_rr got %0d want 0", dut.rr_ptr); end
    tick();
    checks++;
    if (cdb_valid !== 2'b00) begin errors++; $display("FAIL all4_idle got %b want 00", cdb_valid); end
  endtask

  task automatic test_overflow;
    apply_reset();
    cdb_stall = 1'b1;
    set_req(3, 32'h300, 6'd30, 32'h1111);
    tick();
    set_req(3, 32'h304, 6'd31, 32'h2222);
    tick();
    checks++;
    if (req_ready !== 4'b0111 || overflow_err !== 1'b0) begin
      errors++; $display("FAIL ovf_full got ready=%b ovf=%b want 0111 0", req_ready, overflow_err);
    end
    set_req(3, 32'h308, 6'd32, 32'h3333);
    tick();
    req_valid = '0;
    checks++;
    if (overflow_err !== 1'b1 || cdb_valid !== 2'b00) begin
      errors++; $display("FAIL ovf_set got ovf=%b valid=%b want 1 00", overflow_err, cdb_valid);
    end
    cdb_stall = 1'b0;
    tick();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_data[31:0] !== 32'h1111 || cdb_src[1:0] !== REQ_LSQ) begin
      errors++; $display("FAIL ovf_first got valid=%b data=%h src=%0d want 01 1111 3", cdb_valid, cdb_data[31:0], cdb_src[1:0]);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_data[31:0] !== 32'h2222) begin
      errors++; $display("FAIL ovf_second got valid=%b data=%h want 01 2222", cdb_valid, cdb_data[31:0]);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b00 || overflow_err !== 1'b1) begin
      errors++; $display("FAIL ovf_drained got valid=%b ovf=%b want 00 1", cdb_valid, overflow_err);
    end
  endtask

  task automatic test_stall;
    apply_reset();
    cdb_stall = 1'b1;
    set_req(0, 32'h500, 6'd1, 32'hAAAA);
    tick();
    checks++;
    if (cdb_valid !== 2'b00) begin errors++; $display("FAIL stall_c1 got %b want 00", cdb_valid); end
    set_req(0, 32'h504, 6'd2, 32'hBBBB);
    tick();
    req_valid = '0;
    checks++;
    if (cdb_valid !== 2'b00) begin errors++; $display("FAIL stall_c2 got %b want 00", cdb_valid); end
    tick();
    checks++;
    if (cdb_valid !== 2'b00) begin errors++; $display("FAIL stall_c3 got %b want 00", cdb_valid); end
    cdb_stall = 1'b0;
    tick();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_data[31:0] !== 32'hAAAA) begin
      errors++; $display("FAIL stall_rel1 got valid=%b data=%h want 01 aaaa", cdb_valid, cdb_data[31:0]);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_data[31:0] !== 32'hBBBB || cdb_tag[5:0] !== 6'd2) begin
      errors++; $display("FAIL stall_rel2 got valid=%b data=%h tag=%0d want 01 bbbb 2", cdb_valid, cdb_data[31:0], cdb_tag[5:0]);
    end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    set_req(0, 32'h600, 6'd3, 32'hC0);
    tick();
    set_req(0, 32'h604, 6'd4, 32'hC1);
    tick();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_data[31:0] !== 32'hC0) begin
      errors++; $display("FAIL b2b_0 got valid=%b data=%h want 01 c0", cdb_valid, cdb_data[31:0]);
    end
    set_req(0, 32'h608, 6'd5, 32'hC2);
    tick();
    req_valid = '0;
    checks++;
    if (cdb_valid !== 2'b01 || cdb_data[31:0] !== 32'hC1 || req_ready !== 4'b1111) begin
      errors++; $display("FAIL b2b_1 got valid=%b data=%h ready=%b want 01 c1 1111", cdb_valid, cdb_data[31:0], req_ready);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_data[31:0] !== 32'hC2) begin
      errors++; $display("FAIL b2b_2 got valid=%b data=%h want 01 c2", cdb_valid, cdb_data[31:0]);
    end
  endtask

  task automatic test_flush;
    apply_reset();
    cdb_stall = 1'b1;
    set_req(0, 32'h700, 6'd7, 32'hF0);
    set_req(1, 32'h704, 6'd8, 32'hF1);
    tick();
    set_req(2, 32'h708, 6'd9, 32'hF2);
    set_req(3, 32'h70C, 6'd10, 32'hF3);
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    cdb_stall = 1'b0;
    req_valid = '0;
    checks++;
    if (req_ready !== 4'b1111 || cdb_valid !== 2'b00) begin
      errors++; $display("FAIL flush_empty got ready=%b valid=%b want 1111 00", req_ready, cdb_valid);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (cdb_valid !== 2'b00) begin errors++; $display("FAIL flush_quiet%0d got %b want 00", c, cdb_valid); end
    end
  endtask

  task automatic test_async_reset;
    apply_reset();
    cdb_stall = 1'b1;
    set_req(0, 32'h800, 6'd11, 32'hE0);
    set_req(1, 32'h804, 6'd12, 32'hE1);
    set_req(3, 32'h808, 6'd13, 32'hE3);
    tick();
    req_valid = '0;
    set_req(3, 32'h80C, 6'd14, 32'hE4);
    tick();
    req_valid = '0;
    cdb_stall = 1'b0;
    tick();
    checks++;
    if (cdb_valid !== 2'b11 || req_ready !== 4'b0111) begin
      errors++; $display("FAIL arst_pre got valid=%b ready=%b want 11 0111", cdb_valid, req_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cdb_valid !== 2'b00 || req_ready !== 4'b1111 || cdb_data !== '0) begin
      errors++; $display("FAIL arst_now got valid=%b ready=%b data=%h want 00 1111 0", cdb_valid, req_ready, cdb_data);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    cdb_stall = 1'b0;
    req_valid = '0;
    req_pc    = '0;
    req_tag   = '0;
    req_data  = '0;
    test_reset();
    test_single_push();
    test_all_four();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
